// File: rtl/result_display_encoder.sv
// result_display_encoder
//   Turns an 8-bit ALU result into four active-low 7-segment patterns
//   (sign, hundreds, tens, units) for the display multiplexer downstream.
//   Binary-to-BCD is done serially (double dabble, one bit per clock) behind a
//   load/busy/done handshake. The patterns hold the last converted value until
//   the next conversion finishes.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   : leading zero hundreds/tens digits are blanked; units always shown
//     undefined : all three digits are shown, zeros included
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for load; sign and magnitude captured when load is seen
//   S_CONVERT| eight shift-and-adjust steps, one per clock
//   S_ENCODE | BCD digits mapped to segment patterns, done raised next cycle

module result_display_encoder #(
    parameter int SIGNED_MODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [6:0] pattern_3,
    output logic [6:0] pattern_2,
    output logic [6:0] pattern_1,
    output logic [6:0] pattern_0
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_ENCODE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        neg_q;
    logic [7:0]  mag_q;
    logic [11:0] bcd_q;
    logic [2:0]  shift_cnt;

    logic        cap_neg;
    logic [7:0]  cap_mag;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_shift;
    logic [7:0]  mag_shift;

    logic [6:0]  seg_h;
    logic [6:0]  seg_t;
    logic [6:0]  seg_u;
    logic [6:0]  pat3_nxt;
    logic [6:0]  pat2_nxt;
    logic [6:0]  pat1_nxt;
    logic [6:0]  pat0_nxt;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load only matters in S_IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (load) state_nxt = S_CONVERT;
            S_CONVERT: if (shift_cnt == 3'd0) state_nxt = S_ENCODE;
            S_ENCODE:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Sign/magnitude split at capture; 8'h80 yields magnitude 128 in unsigned 8 bits
    always_comb begin
        cap_neg = (SIGNED_MODE != 0) && value[7];
        cap_mag = cap_neg ? (~value + 8'd1) : value;
    end

    // One double-dabble step: adjust each nibble >= 5, then shift {bcd,mag} left
    always_comb begin
        bcd_adj   = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
        bcd_shift = {bcd_adj[10:0], mag_q[7]};
        mag_shift = {mag_q[6:0], 1'b0};
    end

    // Conversion datapath; shift_cnt counts down the remaining steps, terminal at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q     <= 1'b0;
            mag_q     <= 8'd0;
            bcd_q     <= 12'd0;
            shift_cnt <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        neg_q     <= cap_neg;
                        mag_q     <= cap_mag;
                        bcd_q     <= 12'd0;
                        shift_cnt <= 3'd7;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= bcd_shift;
                    mag_q <= mag_shift;
                    if (shift_cnt != 3'd0) begin
                        shift_cnt <= shift_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Digit-to-segment mapping with optional leading-zero suppression
    always_comb begin
        seg_h    = seg_encode(bcd_q[11:8]);
        seg_t    = seg_encode(bcd_q[7:4]);
        seg_u    = seg_encode(bcd_q[3:0]);
        pat3_nxt = neg_q ? SEG_MINUS : SEG_BLANK;
        pat2_nxt = seg_h;
        pat1_nxt = seg_t;
        pat0_nxt = seg_u;
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'd0) begin
            pat2_nxt = SEG_BLANK;
            if (bcd_q[7:4] == 4'd0) begin
                pat1_nxt = SEG_BLANK;
            end
        end
`endif
    end

    // Output registers: patterns change only on the ENCODE edge, done pulses once after it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            pattern_3 <= SEG_BLANK;
            pattern_2 <= SEG_BLANK;
            pattern_1 <= SEG_BLANK;
            pattern_0 <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            if (state == S_ENCODE) begin
                done      <= 1'b1;
                pattern_3 <= pat3_nxt;
                pattern_2 <= pat2_nxt;
                pattern_1 <= pat1_nxt;
                pattern_0 <= pat0_nxt;
            end
        end
    end

endmodule

// File: tb/tb_result_display_encoder.sv
// Testbench for result_display_encoder: a signed and an unsigned instance,
// expected patterns computed from a decimal model and queued at load time.
// Expectations follow LEADING_ZERO_BLANK_EN when the macro is defined.

module tb_result_display_encoder;

    localparam logic [27:0] ALL_BLANK = {4{7'h7F}};

    logic       clk;
    logic       reset;
    logic       load_s;
    logic       load_u;
    logic [7:0] value;

    logic       busy_s, done_s, busy_u, done_u;
    logic [6:0] p3_s, p2_s, p1_s, p0_s;
    logic [6:0] p3_u, p2_u, p1_u, p0_u;

    logic        cur_uns;
    logic        obs_done, obs_busy;
    logic [27:0] obs_pat;

    logic [27:0] exp_q[$];
    logic [27:0] shown_s, shown_u;

    int n_cmp;
    int n_err;

    result_display_encoder #(.SIGNED_MODE(1)) u_signed (
        .clk(clk), .reset(reset), .load(load_s), .value(value),
        .busy(busy_s), .done(done_s),
        .pattern_3(p3_s), .pattern_2(p2_s), .pattern_1(p1_s), .pattern_0(p0_s)
    );

    result_display_encoder #(.SIGNED_MODE(0)) u_unsigned (
        .clk(clk), .reset(reset), .load(load_u), .value(value),
        .busy(busy_u), .done(done_u),
        .pattern_3(p3_u), .pattern_2(p2_u), .pattern_1(p1_u), .pattern_0(p0_u)
    );

    assign obs_done = cur_uns ? done_u : done_s;
    assign obs_busy = cur_uns ? busy_u : busy_s;
    assign obs_pat  = cur_uns ? {p3_u, p2_u, p1_u, p0_u} : {p3_s, p2_s, p1_s, p0_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] model(input logic [7:0] v, input logic uns);
        int n, m, h, t, u;
        logic [6:0] s3, s2, s1, s0;
        n  = (!uns && v[7]) ? int'(v) - 256 : int'(v);
        m  = (n < 0) ? -n : n;
        h  = m / 100;
        t  = (m / 10) % 10;
        u  = m % 10;
        s3 = (n < 0) ? 7'h3F : 7'h7F;
        s2 = seg(h);
        s1 = seg(t);
        s0 = seg(u);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) s2 = 7'h7F;
        if (h == 0 && t == 0) s1 = 7'h7F;
`endif
        return {s3, s2, s1, s0};
    endfunction

    // Drive load for one edge (T0); value is scrambled afterwards to prove it is only sampled at T0
    task automatic start(input logic uns, input logic [7:0] v);
        cur_uns = uns;
        value   = v;
        if (uns) load_u = 1'b1;
        else     load_s = 1'b1;
        exp_q.push_back(model(v, uns));
        @(posedge clk);
        #1;
        load_s = 1'b0;
        load_u = 1'b0;
        value  = ~v;
    endtask

    // Wait for done; check latency, busy, pattern stability, then pop and compare
    task automatic finish_conv(input int inject_at, input logic [7:0] inj_v);
        int c;
        logic got;
        logic [27:0] e, shown;
        c     = 0;
        got   = 1'b0;
        shown = cur_uns ? shown_u : shown_s;
        while (!got && c < 20) begin
            if (c == inject_at - 1) begin
                value = inj_v;
                if (cur_uns) load_u = 1'b1;
                else         load_s = 1'b1;
            end
            @(posedge clk);
            #1;
            load_s = 1'b0;
            load_u = 1'b0;
            c++;
            if (obs_done) begin
                got = 1'b1;
            end else begin
                n_cmp++;
                if (obs_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_mid cycle=%0d got=%b want=1", c, obs_busy);
                end
                n_cmp++;
                if (obs_pat !== shown) begin
                    n_err++;
                    $display("FAIL pattern_hold cycle=%0d got=%h want=%h", c, obs_pat, shown);
                end
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ALL_BLANK;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout got=no_done want=done_by_cycle_9");
        end else begin
            if (c != 9) begin
                n_err++;
                $display("FAIL latency got=%0d want=9", c);
            end
            n_cmp++;
            if (obs_busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_with_done got=%b want=0", obs_busy);
            end
            n_cmp++;
            if (obs_pat !== e) begin
                n_err++;
                $display("FAIL patterns got=%h want=%h", obs_pat, e);
            end
            if (cur_uns) shown_u = e;
            else         shown_s = e;
        end
    endtask

    task automatic check_done_drops();
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_done !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse_width got=%b want=0", obs_done);
        end
    endtask

    task automatic check_quiet(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_s || done_u || busy_s || busy_u) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL %s_quiet got=%0d_active_cycles want=0", tag, seen);
        end
    endtask

    task automatic conv(input logic uns, input logic [7:0] v);
        start(uns, v);
        finish_conv(-1, 8'h00);
        check_done_drops();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({p3_s, p2_s, p1_s, p0_s, p3_u, p2_u, p1_u, p0_u} !== {ALL_BLANK, ALL_BLANK}) begin
            n_err++;
            $display("FAIL reset_patterns got=%h_%h want=all_7F",
                     {p3_s, p2_s, p1_s, p0_s}, {p3_u, p2_u, p1_u, p0_u});
        end
        n_cmp++;
        if ({busy_s, done_s, busy_u, done_u} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=0000", {busy_s, done_s, busy_u, done_u});
        end
        @(negedge clk);
        reset = 1'b0;
        check_quiet(20, "post_reset");
        n_cmp++;
        if ({p3_s, p2_s, p1_s, p0_s, p3_u, p2_u, p1_u, p0_u} !== {ALL_BLANK, ALL_BLANK}) begin
            n_err++;
            $display("FAIL idle_patterns got=%h_%h want=all_7F",
                     {p3_s, p2_s, p1_s, p0_s}, {p3_u, p2_u, p1_u, p0_u});
        end
    endtask

    task automatic test_signed();
        logic [7:0] vec[8];
        vec = '{8'h05, 8'h80, 8'hFF, 8'hF6, 8'h09, 8'h7F, 8'h00, 8'hC8};
        foreach (vec[i]) conv(1'b0, vec[i]);
    endtask

    task automatic test_unsigned();
        logic [7:0] vec[6];
        vec = '{8'hFF, 8'h00, 8'h80, 8'h64, 8'h0A, 8'h09};
        foreach (vec[i]) conv(1'b1, vec[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            conv(1'b0, 8'($urandom_range(0, 255)));
            conv(1'b1, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_load_while_busy();
        start(1'b0, 8'h7B);
        finish_conv(3, 8'h01);
        check_quiet(12, "ignored_load");
    endtask

    task automatic test_back_to_back();
        start(1'b0, 8'h2A);
        finish_conv(-1, 8'h00);
        start(1'b0, 8'hD6);
        finish_conv(-1, 8'h00);
        start(1'b1, 8'hC7);
        finish_conv(-1, 8'h00);
        check_done_drops();
    endtask

    task automatic test_abort();
        start(1'b0, 8'h63);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        shown_s = ALL_BLANK;
        shown_u = ALL_BLANK;
        #1;
        n_cmp++;
        if ({p3_s, p2_s, p1_s, p0_s} !== ALL_BLANK) begin
            n_err++;
            $display("FAIL abort_patterns got=%h want=%h", {p3_s, p2_s, p1_s, p0_s}, ALL_BLANK);
        end
        n_cmp++;
        if ({busy_s, done_s} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_flags got=%b want=00", {busy_s, done_s});
        end
        @(negedge clk);
        reset = 1'b0;
        check_quiet(15, "after_abort");
        conv(1'b0, 8'h81);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        load_s  = 1'b0;
        load_u  = 1'b0;
        value   = 8'h00;
        cur_uns = 1'b0;
        shown_s = ALL_BLANK;
        shown_u = ALL_BLANK;
        test_reset();
        test_signed();
        test_unsigned();
        test_load_while_busy();
        test_back_to_back();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
